// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath blocks: pooling mode and window FSM state.
package cnn_pkg;

    typedef enum logic [1:0] {
        RED_SUM = 2'd0,
        RED_MAX = 2'd1,
        RED_AVG = 2'd2
    } reduce_mode_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/column_reduce.sv
// Combinational reduction of one activation column into its exact sum and its maximum.
module column_reduce #(
    parameter int DATA_WIDTH = 16,
    parameter int MAT_HEIGHT = 2
) (
    input  logic [DATA_WIDTH-1:0]                    column [MAT_HEIGHT],
    output logic [DATA_WIDTH+$clog2(MAT_HEIGHT)-1:0] col_sum,
    output logic [DATA_WIDTH-1:0]                    col_max
);

    localparam int SUM_W = DATA_WIDTH + $clog2(MAT_HEIGHT);

    // Written as a chain; synthesis rebalances it into a tree.
    always_comb begin
        col_sum = '0;
        col_max = '0;
        for (int i = 0; i < MAT_HEIGHT; i++) begin
            col_sum = col_sum + SUM_W'(column[i]);
            if (column[i] > col_max) col_max = column[i];
        end
    end

endmodule

// File: rtl/window_reduce.sv
// Windowed sum/max/average over MAT_HEIGHT x WIN_COLS activations with valid/ready on both sides.
module window_reduce
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAT_HEIGHT = 2,
    parameter int WIN_COLS   = 2,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(MAT_HEIGHT * WIN_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  reduce_mode_t          mode,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] column [MAT_HEIGHT],
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [OUT_WIDTH-1:0]  result
);

    localparam int SUM_W = DATA_WIDTH + $clog2(MAT_HEIGHT);
    localparam int SHIFT = $clog2(MAT_HEIGHT * WIN_COLS);
    localparam int CNT_W = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIN_COLS - 1);

    if (MAT_HEIGHT < 1 || WIN_COLS < 1) begin : g_bad_dims
        $error("window_reduce: MAT_HEIGHT and WIN_COLS must be at least 1");
    end
    if (((MAT_HEIGHT * WIN_COLS) & (MAT_HEIGHT * WIN_COLS - 1)) != 0) begin : g_bad_avg
        $error("window_reduce: window size must be a power of two for averaging");
    end
    if (OUT_WIDTH != DATA_WIDTH + $clog2(MAT_HEIGHT * WIN_COLS)) begin : g_bad_ow
        $error("window_reduce: OUT_WIDTH is derived and must not be overridden");
    end

    logic [SUM_W-1:0]      col_sum;
    logic [DATA_WIDTH-1:0] col_max;

    column_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAT_HEIGHT (MAT_HEIGHT)
    ) u_col (
        .column  (column),
        .col_sum (col_sum),
        .col_max (col_max)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      col_cnt_q, col_cnt_d;
    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    reduce_mode_t          mode_q, mode_d;
    logic [OUT_WIDTH-1:0]  result_q, result_d;
    logic                  valid_out_q, valid_out_d;

    logic                  accept, first, last;
    reduce_mode_t          eff_mode;
    logic [OUT_WIDTH-1:0]  new_acc, final_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            col_cnt_q   <= '0;
            acc_q       <= '0;
            mode_q      <= RED_SUM;
            result_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            valid_out_q <= valid_out_d;
        end
    end

    always_comb begin
        accept   = valid_in && ready_in;
        first    = (col_cnt_q == '0);
        last     = (col_cnt_q == LAST_COL);
        // The first column of a window obeys the live mode, later ones the latched mode.
        eff_mode = first ? mode : mode_q;
        if (eff_mode == RED_MAX) begin
            if (first || (OUT_WIDTH'(col_max) > acc_q)) new_acc = OUT_WIDTH'(col_max);
            else                                        new_acc = acc_q;
        end else begin
            new_acc = (first ? '0 : acc_q) + OUT_WIDTH'(col_sum);
        end
        final_val = (eff_mode == RED_AVG) ? (new_acc >> SHIFT) : new_acc;

        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        result_d    = result_q;
        valid_out_d = valid_out_q;

        if (clear) begin
            state_d     = ACCUM;
            col_cnt_d   = '0;
            acc_d       = '0;
            valid_out_d = 1'b0;
        end else begin
            if (state_q == HOLD && ready_out) begin
                state_d     = ACCUM;
                valid_out_d = 1'b0;
            end
            if (accept) begin
                acc_d = new_acc;
                if (first) mode_d = mode;
                if (last) begin
                    result_d    = final_val;
                    valid_out_d = 1'b1;
                    state_d     = HOLD;
                    col_cnt_d   = '0;
                end else begin
                    col_cnt_d = col_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready_in  = (state_q == ACCUM) || ready_out;
        valid_out = valid_out_q;
        result    = result_q;
    end

endmodule
